// File: rtl/btn_conditioner.sv
// N-channel push-button front end: synchroniser, tick-based debounce,
// press/release pulses, long-press flag and auto-repeat per channel.
module btn_conditioner #(
  parameter int N_BTN          = 4,
  parameter int TICK_DIV       = 3_333_333,
  parameter int STABLE_SAMPLES = 3,
  parameter int HOLD_TICKS     = 30,
  parameter int REPEAT_TICKS   = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_BTN-1:0] btn_in,
  input  logic [N_BTN-1:0] repeat_en,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release,
  output logic [N_BTN-1:0] btn_long,
  output logic [N_BTN-1:0] btn_repeat,
  output logic             tick
);

  localparam int DW = $clog2(TICK_DIV + 1);
  localparam int SW = $clog2(STABLE_SAMPLES + 1);
  localparam int HW = $clog2(HOLD_TICKS + 1);
  localparam int RW = $clog2(REPEAT_TICKS + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DOWN = 2'd1,
    LONG = 2'd2
  } state_t;

  logic [DW-1:0] div_q, div_d;
  logic          tick_w;

  assign tick_w = (div_q == DW'(TICK_DIV - 1));
  assign tick   = tick_w;

  always_comb begin
    div_d = div_q + 1'b1;
    if (tick_w) div_d = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) div_q <= '0;
    else       div_q <= div_d;
  end

  logic [N_BTN-1:0] sync1_q, sync1_d;
  logic [N_BTN-1:0] sync2_q, sync2_d;

  always_comb begin
    sync1_d = btn_in;
    sync2_d = sync1_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

  for (genvar g = 0; g < N_BTN; g++) begin : g_ch
    logic [SW-1:0] agree_q, agree_d;
    logic          lvl_q, lvl_d;
    state_t        st_q, st_d;
    logic [HW-1:0] hold_q, hold_d;
    logic [RW-1:0] rep_q, rep_d;
    logic          press_q, press_d;
    logic          rel_q, rel_d;
    logic          long_q, long_d;
    logic          rpt_q, rpt_d;
    logic          rise, fall;

    always_comb begin
      agree_d = agree_q;
      lvl_d   = lvl_q;
      if (tick_w) begin
        if (sync2_q[g] != lvl_q) begin
          if (agree_q == SW'(STABLE_SAMPLES - 1)) begin
            lvl_d   = ~lvl_q;
            agree_d = '0;
          end else begin
            agree_d = agree_q + 1'b1;
          end
        end else begin
          agree_d = '0;
        end
      end
    end

    assign rise = lvl_d & ~lvl_q;
    assign fall = ~lvl_d & lvl_q;

    // Release on a tick wins over any hold/repeat progress.
    always_comb begin
      st_d    = st_q;
      hold_d  = hold_q;
      rep_d   = rep_q;
      long_d  = long_q;
      press_d = 1'b0;
      rel_d   = 1'b0;
      rpt_d   = 1'b0;
      unique case (st_q)
        IDLE: begin
          if (rise) begin
            st_d    = DOWN;
            press_d = 1'b1;
            hold_d  = '0;
          end
        end
        DOWN: begin
          if (fall) begin
            st_d   = IDLE;
            rel_d  = 1'b1;
            long_d = 1'b0;
          end else if (tick_w) begin
            hold_d = hold_q + 1'b1;
            if (hold_q == HW'(HOLD_TICKS - 1)) begin
              st_d   = LONG;
              long_d = 1'b1;
              rep_d  = '0;
              rpt_d  = repeat_en[g];
            end
          end
        end
        LONG: begin
          if (fall) begin
            st_d   = IDLE;
            rel_d  = 1'b1;
            long_d = 1'b0;
          end else if (!repeat_en[g]) begin
            rep_d = '0;
          end else if (tick_w) begin
            if (rep_q == RW'(REPEAT_TICKS - 1)) begin
              rpt_d = 1'b1;
              rep_d = '0;
            end else begin
              rep_d = rep_q + 1'b1;
            end
          end
        end
        default: begin
          st_d = IDLE;
        end
      endcase
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        agree_q <= '0;
        lvl_q   <= 1'b0;
        st_q    <= IDLE;
        hold_q  <= '0;
        rep_q   <= '0;
        press_q <= 1'b0;
        rel_q   <= 1'b0;
        long_q  <= 1'b0;
        rpt_q   <= 1'b0;
      end else begin
        agree_q <= agree_d;
        lvl_q   <= lvl_d;
        st_q    <= st_d;
        hold_q  <= hold_d;
        rep_q   <= rep_d;
        press_q <= press_d;
        rel_q   <= rel_d;
        long_q  <= long_d;
        rpt_q   <= rpt_d;
      end
    end

    assign btn_level[g]   = lvl_q;
    assign btn_press[g]   = press_q;
    assign btn_release[g] = rel_q;
    assign btn_long[g]    = long_q;
    assign btn_repeat[g]  = rpt_q;
  end

endmodule

// File: tb/tb_btn_conditioner.sv
// Bench for btn_conditioner: directed scenarios plus random bouncing,
// checked every cycle against a tick-counting reference model.
module tb_btn_conditioner;

  localparam int N  = 2;
  localparam int TD = 4;
  localparam int ST = 3;
  localparam int HT = 5;
  localparam int RT = 2;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [N-1:0] btn_in = '0;
  logic [N-1:0] repeat_en = '0;
  logic [N-1:0] btn_level, btn_press, btn_release, btn_long, btn_repeat;
  logic         tick;

  btn_conditioner #(
    .N_BTN(N), .TICK_DIV(TD), .STABLE_SAMPLES(ST),
    .HOLD_TICKS(HT), .REPEAT_TICKS(RT)
  ) dut (
    .clk(clk), .reset(reset), .btn_in(btn_in), .repeat_en(repeat_en),
    .btn_level(btn_level), .btn_press(btn_press),
    .btn_release(btn_release), .btn_long(btn_long),
    .btn_repeat(btn_repeat), .tick(tick)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // reference model state
  int           ncyc;
  logic [N-1:0] m_s1, m_s2;
  logic [N-1:0] m_lvl, m_prs, m_rel, m_lng, m_rpt;
  logic         m_tick;
  int           streak [N];
  int           tsp    [N];
  int           srep   [N];

  task automatic model_edge();
    bit tk;
    bit nl;
    if (reset) begin
      ncyc = 0;
      m_s1 = '0; m_s2 = '0;
      m_lvl = '0; m_prs = '0; m_rel = '0; m_lng = '0; m_rpt = '0;
      for (int ch = 0; ch < N; ch++) begin
        streak[ch] = 0; tsp[ch] = 0; srep[ch] = 0;
      end
    end else begin
      tk = ((ncyc % TD) == TD - 1);
      for (int ch = 0; ch < N; ch++) begin
        nl = m_lvl[ch];
        if (tk) begin
          if (m_s2[ch] != m_lvl[ch]) begin
            streak[ch]++;
            if (streak[ch] == ST) begin
              nl = !m_lvl[ch];
              streak[ch] = 0;
            end
          end else begin
            streak[ch] = 0;
          end
        end
        m_prs[ch] = nl && !m_lvl[ch];
        m_rel[ch] = !nl && m_lvl[ch];
        m_rpt[ch] = 1'b0;
        if (m_prs[ch]) begin
          tsp[ch] = 0;
        end else if (m_rel[ch]) begin
          m_lng[ch] = 1'b0;
        end else if (m_lvl[ch] && tk) begin
          if (tsp[ch] < HT) begin
            tsp[ch]++;
            if (tsp[ch] == HT) begin
              m_lng[ch] = 1'b1;
              srep[ch]  = 0;
              m_rpt[ch] = repeat_en[ch];
            end
          end else if (repeat_en[ch]) begin
            srep[ch]++;
            if (srep[ch] == RT) begin
              m_rpt[ch] = 1'b1;
              srep[ch]  = 0;
            end
          end
        end
        if (m_lng[ch] && !repeat_en[ch]) srep[ch] = 0;
        m_lvl[ch] = nl;
      end
      ncyc++;
      m_s2 = m_s1;
      m_s1 = btn_in;
    end
    m_tick = ((ncyc % TD) == TD - 1);
  endtask

  task automatic chk(input string tag, input logic [1:0] obs,
                     input logic [1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%b expected=%b t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic chki(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    chk("level",   btn_level,   m_lvl);
    chk("press",   btn_press,   m_prs);
    chk("release", btn_release, m_rel);
    chk("long",    btn_long,    m_lng);
    chk("repeat",  btn_repeat,  m_rpt);
    chk("tick",    {1'b0, tick}, {1'b0, m_tick});
  endtask

  initial begin
    int c, ft, fp, nrel, np, nlv, nr, ls;

    // reset with both buttons held
    reset = 1'b1;
    btn_in = 2'b11;
    repeat (5) step();
    chki("reset_outputs",
         {btn_level, btn_press, btn_release, btn_long, btn_repeat, tick}, 0);
    reset = 1'b0;
    ft = -1;
    fp = -1;
    for (int k = 1; k <= 20; k++) begin
      step();
      if (tick && ft < 0) ft = k;
      if (btn_press != 0 && fp < 0) fp = k;
    end
    chki("first_tick", ft, 3);
    chki("first_press", fp, 12);
    btn_in = 2'b00;
    repeat (40) step();

    // single press on channel 0, long press and repeat
    btn_in = 2'b01;
    repeat_en = 2'b01;
    c = 0;
    do begin step(); c++; end while (!btn_press[0] && c < 40);
    chki("ch0_press_only", int'(btn_press), 1);
    c = 0;
    do begin step(); c++; end while (!btn_long[0] && c < 100);
    chki("press_to_long", c, 20);
    chki("first_repeat_at_long", int'(btn_repeat[0]), 1);
    c = 0;
    do begin step(); c++; end while (!btn_repeat[0] && c < 50);
    chki("repeat_period", c, 8);
    btn_in = 2'b00;
    nrel = 0;
    repeat (40) begin
      step();
      if (btn_release[0]) nrel++;
    end
    chki("release_count", nrel, 1);

    // short glitches never qualify
    np = 0;
    nlv = 0;
    for (int k = 0; k < 60; k++) begin
      btn_in = ((k / 6) % 2 == 0) ? 2'b01 : 2'b00;
      step();
      if (btn_press[0] || btn_release[0]) np++;
      if (btn_level[0]) nlv++;
    end
    btn_in = 2'b00;
    repeat (20) begin
      step();
      if (btn_press[0] || btn_release[0]) np++;
      if (btn_level[0]) nlv++;
    end
    chki("glitch_pulses", np, 0);
    chki("glitch_level", nlv, 0);

    // long press without repeat
    repeat_en = 2'b00;
    btn_in = 2'b01;
    nr = 0;
    ls = 0;
    repeat (80) begin
      step();
      if (btn_repeat[0]) nr++;
      if (btn_long[0]) ls = 1;
    end
    chki("norep_long_seen", ls, 1);
    chki("norep_repeats", nr, 0);
    btn_in = 2'b00;
    repeat (30) step();

    // simultaneous channels
    btn_in = 2'b11;
    c = 0;
    do begin step(); c++; end while (btn_press == 0 && c < 40);
    chki("both_press", int'(btn_press), 3);
    repeat (10) step();
    btn_in = 2'b00;
    c = 0;
    do begin step(); c++; end while (btn_release == 0 && c < 40);
    chki("both_release", int'(btn_release), 3);
    repeat (20) step();

    // reset while in long press
    repeat_en = 2'b01;
    btn_in = 2'b01;
    c = 0;
    do begin step(); c++; end while (!btn_long[0] && c < 100);
    chki("long_before_reset", int'(btn_long[0]), 1);
    reset = 1'b1;
    step();
    chki("reset_mid_outputs",
         {btn_level, btn_press, btn_release, btn_long, btn_repeat, tick}, 0);
    reset = 1'b0;
    c = 0;
    do begin step(); c++; end while (!btn_press[0] && c < 40);
    chki("reset_repress", c, 12);
    btn_in = 2'b00;
    repeat (30) step();

    // random bouncing, holds, repeat enables and resets
    for (int s = 0; s < 40; s++) begin
      logic [1:0] tgt;
      tgt = 2'($urandom);
      repeat_en = 2'($urandom);
      for (int k = 0; k < 80; k++) begin
        btn_in = (k < 16) ? 2'($urandom) : tgt;
        if (k == 40 && $urandom_range(0, 3) == 0) repeat_en = 2'($urandom);
        reset = (k == 60 && $urandom_range(0, 9) == 0);
        step();
      end
    end
    reset = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/btn_conditioner.md
Name: btn_conditioner

Overview:
- Parametrised N-channel push-button front end that replaces per-design ad-hoc debounce/edge-detect logic.
- Per channel: synchronises the raw pad input, debounces it on a shared sample tick, and emits a debounced level, one-cycle press and release pulses, a long-press flag and optional auto-repeat pulses.
- Sits between board buttons and the application FSMs (timer entry, menu stepping). All outputs are synchronous to clk.

Parameters:
- N_BTN, 4, number of independent button channels (>=1).
- TICK_DIV, 3_333_333, clk cycles per sample tick (>=2).
- STABLE_SAMPLES, 3, consecutive disagreeing ticks needed to change the debounced level (>=1).
- HOLD_TICKS, 30, ticks after the press before long-press is declared (>=1).
- REPEAT_TICKS, 6, ticks between auto-repeat pulses once in long-press (>=1).

Ports:
- clk  input  1  system clock; the only clock.
- reset  input  1  synchronous, active-high reset.
- btn_in  input  N_BTN  raw, asynchronous, bouncy button inputs; 1 = pressed.
- repeat_en  input  N_BTN  per-channel auto-repeat enable, synchronous to clk.
- btn_level  output  N_BTN  debounced level.
- btn_press  output  N_BTN  one-clk pulse on a debounced 0->1 transition.
- btn_release  output  N_BTN  one-clk pulse on a debounced 1->0 transition.
- btn_long  output  N_BTN  high while in long-press.
- btn_repeat  output  N_BTN  one-clk auto-repeat pulses.
- tick  output  1  shared sample strobe, for debug and bench alignment.

Behaviour:
- Reset (synchronous, active-high): clears every output, the divider, synchroniser flops, debounce counters, hold and repeat counters. All channels return to IDLE.
- Tick divider:
  - Counter runs 0..TICK_DIV-1 and wraps.
  - tick is high for exactly the one clk in which the counter equals TICK_DIV-1.
  - The first tick after reset release occurs TICK_DIV-1 cycles after the first non-reset edge.
- Synchroniser: two flops per channel, clocked every clk. sync = second flop.
- Debounce (evaluated on tick only):
  - If sync != btn_level, the channel's agree count increments; otherwise it clears to 0.
  - When the count reaches STABLE_SAMPLES, btn_level toggles and the count clears, on that same clk edge.
  - A disagreement that does not persist for STABLE_SAMPLES consecutive ticks never changes btn_level.
- Per-channel FSM states: IDLE, DOWN, LONG.
  - IDLE -> DOWN:
    - Trigger: btn_level rises.
    - btn_press = 1 for exactly that clk.
    - hold_cnt <= 0.
  - DOWN:
    - On each tick that does not cause a release, hold_cnt increments.
    - When the incremented value equals HOLD_TICKS: go to LONG, set btn_long <= 1, and rep_cnt <= 0.
    - On that same edge, btn_repeat pulses if repeat_en = 1.
  - LONG:
    - On each tick that does not cause a release, if repeat_en = 1, rep_cnt increments.
    - When rep_cnt reaches REPEAT_TICKS: pulse btn_repeat for one clk and clear rep_cnt.
    - If repeat_en = 0: rep_cnt is held at 0 and no repeat pulses are emitted. The next repeat comes REPEAT_TICKS ticks after repeat_en is reasserted.
  - DOWN or LONG -> IDLE:
    - Trigger: btn_level falls.
    - btn_release = 1 for one clk; btn_long <= 0 on the same edge.
    - A release tick takes priority: no hold or repeat increment and no repeat pulse on that tick.
- Pulse rules: btn_press, btn_release and btn_repeat are never high for more than one clk. press and release on the same channel are never high together.
- Channels are fully independent. Simultaneous events on different channels are all reported in the same cycle.
- Reset mid-operation:
  - No release pulse is generated.
  - A button still held after reset release is re-detected as a new press after two sync cycles plus STABLE_SAMPLES ticks.
- Widths: counters sized with $clog2 of their limit + 1. No counter ever wraps past its limit.

Test Plan:
(Parameters: N_BTN=2, TICK_DIV=4, STABLE_SAMPLES=3, HOLD_TICKS=5, REPEAT_TICKS=2.)
- Reset held 5 cycles, btn_in=2'b11 -> all outputs 0 during reset; first tick 3 cycles after release; no press before the third tick that sees sync=1.
- btn_in[0] rises and stays high -> btn_level[0] and btn_press[0] rise on the 3rd qualifying tick; press lasts exactly 1 clk; channel 1 outputs stay 0.
- btn_in[0] toggles every 6 cycles for 60 cycles, then stays low -> no press, release or level change.
- Hold btn_in[0] with repeat_en[0]=1 -> btn_long and the first btn_repeat occur 5 ticks (20 clk) after press, then repeats every 8 clk. Release -> level falls after 3 ticks with a single release pulse and btn_long low on the same edge; with repeat_en[0]=0 -> btn_long asserts and there are zero repeat pulses.
- Both btn_in bits rise on the same cycle -> btn_press=2'b11 on the same single clk; release both -> btn_release=2'b11 on the same clk.
- Reset asserted for 1 cycle while channel 0 is in LONG and still held -> all outputs 0 on the next edge with no release pulse; a new press is detected 2 sync cycles plus 3 ticks later.
